// File: rtl/filter_tdm_if.sv
// filter_tdm_if: bundle of the event, evaluation, step-lookup and result
// signals of filter_tdm.
//   master : event/eval producer and step-table owner (drives push, in_val,
//            in_time, eval_start, eval_time, step_in)
//   slave  : the filter (drives push_ready, busy, tap_req, tap_idx, tap_dt,
//            out_valid, out)
interface filter_tdm_if #(
  parameter int DEPTH  = 8,
  parameter int IN_W   = 16,
  parameter int DT_W   = 24,
  parameter int STEP_W = 18,
  parameter int OUT_W  = 24
);
  localparam int IDX_W = $clog2(DEPTH);

  logic                     push;
  logic                     push_ready;
  logic signed [IN_W-1:0]   in_val;
  logic [DT_W-1:0]          in_time;
  logic                     eval_start;
  logic [DT_W-1:0]          eval_time;
  logic                     busy;
  logic                     tap_req;
  logic [IDX_W-1:0]         tap_idx;
  logic [DT_W-1:0]          tap_dt;
  logic signed [STEP_W-1:0] step_in;
  logic                     out_valid;
  logic signed [OUT_W-1:0]  out;

  modport master (
    output push, in_val, in_time, eval_start, eval_time, step_in,
    input  push_ready, busy, tap_req, tap_idx, tap_dt, out_valid, out
  );

  modport slave (
    input  push, in_val, in_time, eval_start, eval_time, step_in,
    output push_ready, busy, tap_req, tap_idx, tap_dt, out_valid, out
  );
endinterface

// File: rtl/filter_tdm.sv
// filter_tdm: time-multiplexed event-driven channel filter.
// Keeps a DEPTH-entry ring of (value, timestamp) events. An evaluation walks
// the taps newest-first through one external step table and one multiplier,
// accumulating value_k * (step_k - step_{k-1}). Result appears DEPTH+STEP_LAT+2
// cycles after eval_start is accepted.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   bus       : filter_tdm_if.slave (push/eval inputs, tap lookup, result)
//   sat_flag  : only with FILTER_TDM_SAT_EN; set with out_valid on clipping
// Build option: define FILTER_TDM_SAT_EN to saturate out instead of wrapping.
//
// state | meaning
// IDLE  | waiting for eval_start; pushes accepted
// ISSUE | tap_req high, tap_idx 0..DEPTH-1
// DRAIN | waiting for last step sample and product
// DONE  | out_valid for one cycle
module filter_tdm #(
  parameter int DEPTH      = 8,
  parameter int IN_W       = 16,
  parameter int DT_W       = 24,
  parameter int STEP_W     = 18,
  parameter int PROD_SHIFT = 8,
  parameter int ACC_W      = 40,
  parameter int OUT_W      = 24,
  parameter int STEP_LAT   = 2
) (
  input  logic clk,
  input  logic rst,
  filter_tdm_if.slave bus
`ifdef FILTER_TDM_SAT_EN
  ,
  output logic sat_flag
`endif
);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(STEP_LAT + 1);
  localparam int PROD_W = STEP_W + 1 + IN_W;
  localparam int L      = STEP_LAT - 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;
  state_t state, state_nx;

  logic signed [IN_W-1:0]   val_hist [DEPTH];
  logic [DT_W-1:0]          time_hist [DEPTH];
  logic [DEPTH-1:0]         vld_hist;
  logic [IDX_W-1:0]         wptr, rptr, idx;
  logic [DT_W-1:0]          eval_cap;
  logic [CNT_W-1:0]         drain_cnt;
  logic                     busy, tap_req, out_valid;

  logic signed [IN_W-1:0]   tap_val;
  logic signed [IN_W-1:0]   val_pipe [STEP_LAT];
  logic [STEP_LAT-1:0]      req_pipe, first_pipe;
  logic signed [STEP_W-1:0] step_prev, step_base;
  logic signed [STEP_W:0]   pulse;
  logic signed [PROD_W-1:0] prod_full, prod_shift;
  logic signed [ACC_W-1:0]  prod, acc;
  logic                     prod_vld;
  logic signed [OUT_W-1:0]  out_next, out_q;

  function automatic logic [IDX_W-1:0] inc_ptr(input logic [IDX_W-1:0] p);
    return (p == LAST_IDX) ? '0 : p + IDX_W'(1);
  endfunction

  function automatic logic [IDX_W-1:0] dec_ptr(input logic [IDX_W-1:0] p);
    return (p == '0) ? LAST_IDX : p - IDX_W'(1);
  endfunction

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // FSM: next state
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (bus.eval_start)    state_nx = S_ISSUE;
      S_ISSUE: if (idx == LAST_IDX)   state_nx = S_DRAIN;
      S_DRAIN: if (drain_cnt == '0)   state_nx = S_DONE;
      S_DONE:                         state_nx = S_IDLE;
      default:                        state_nx = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy      = (state != S_IDLE);
    tap_req   = (state == S_ISSUE);
    out_valid = (state == S_DONE);
  end

  // History, read pointer, tap index and drain timer
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_hist  <= '0;
      wptr      <= '0;
      rptr      <= '0;
      idx       <= '0;
      eval_cap  <= '0;
      drain_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        val_hist[i]  <= '0;
        time_hist[i] <= '0;
      end
    end else begin
      if (bus.push && !busy) begin
        val_hist[wptr]  <= bus.in_val;
        time_hist[wptr] <= bus.in_time;
        vld_hist[wptr]  <= 1'b1;
        wptr            <= inc_ptr(wptr);
      end
      case (state)
        S_IDLE: if (bus.eval_start) begin
          eval_cap <= bus.eval_time;
          // a same-cycle push lands at wptr and must become tap 0
          rptr     <= bus.push ? wptr : dec_ptr(wptr);
          idx      <= '0;
        end
        S_ISSUE: begin
          rptr      <= dec_ptr(rptr);
          idx       <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
          drain_cnt <= CNT_W'(STEP_LAT);
        end
        S_DRAIN: drain_cnt <= drain_cnt - CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign tap_val = vld_hist[rptr] ? val_hist[rptr] : '0;

  // Carry each tap's value alongside its outstanding lookup
  always_ff @(posedge clk) begin
    if (rst) begin
      req_pipe   <= '0;
      first_pipe <= '0;
      for (int i = 0; i < STEP_LAT; i++) val_pipe[i] <= '0;
    end else begin
      req_pipe[0]   <= tap_req;
      first_pipe[0] <= (idx == '0);
      val_pipe[0]   <= tap_val;
      for (int i = 1; i < STEP_LAT; i++) begin
        req_pipe[i]   <= req_pipe[i-1];
        first_pipe[i] <= first_pipe[i-1];
        val_pipe[i]   <= val_pipe[i-1];
      end
    end
  end

  always_comb begin
    step_base  = first_pipe[L] ? '0 : step_prev;
    pulse      = (STEP_W+1)'(bus.step_in) - (STEP_W+1)'(step_base);
    prod_full  = pulse * val_pipe[L];
    prod_shift = prod_full >>> PROD_SHIFT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      step_prev <= '0;
      prod      <= '0;
      prod_vld  <= 1'b0;
      acc       <= '0;
    end else begin
      prod_vld <= req_pipe[L];
      if (req_pipe[L]) begin
        step_prev <= bus.step_in;
        prod      <= ACC_W'(prod_shift);
      end
      if (state == S_IDLE && bus.eval_start) acc <= '0;
      else if (prod_vld)                     acc <= acc + prod;
    end
  end

`ifdef FILTER_TDM_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    $signed({{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
  logic clip_hi, clip_lo, sat_q;

  always_comb begin
    clip_hi  = (acc > SAT_MAX);
    clip_lo  = (acc < SAT_MIN);
    out_next = clip_hi ? SAT_MAX[OUT_W-1:0] :
               clip_lo ? SAT_MIN[OUT_W-1:0] : acc[OUT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst)                  sat_q <= 1'b0;
    else if (state == S_DONE) sat_q <= clip_hi | clip_lo;
  end

  assign sat_flag = out_valid ? (clip_hi | clip_lo) : sat_q;
`else
  always_comb out_next = acc[OUT_W-1:0];
`endif

  // Result is presented combinationally in DONE and held afterwards
  always_ff @(posedge clk) begin
    if (rst)                  out_q <= '0;
    else if (state == S_DONE) out_q <= out_next;
  end

  assign bus.out        = out_valid ? out_next : out_q;
  assign bus.out_valid  = out_valid;
  assign bus.busy       = busy;
  assign bus.push_ready = !busy;
  assign bus.tap_req    = tap_req;
  assign bus.tap_idx    = idx;
  assign bus.tap_dt     = eval_cap - time_hist[rptr];
endmodule
